// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   ST_IDLE  : waiting for start
//   ST_SHIFT : one operand bit pair consumed per clock, LSB first
//   ST_DONE  : result just landed in the output registers (one cycle)
// Encoding 2'd3 is unused; the FSM falls back to ST_IDLE if it ever lands there.
package bit_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// Existing 1-bit full-adder cell, purely combinational.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: {cout_out, sum_out} = a_in + b_in + cin, one bit per clock,
// LSB first, through a single full-adder cell.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request, honoured in IDLE or DONE (ignored while busy)
//   a_in, b_in : operands, captured on an accepted start
//   cin        : carry-in, captured on an accepted start
//   busy       : high while bits are being shifted through the cell
//   done       : one-cycle pulse when sum_out/cout_out are newly valid
//   sum_out    : result of the last completed add, held until the next one
//   cout_out   : carry-out of the last completed add, held likewise
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             cell_sum;
    logic             cell_cout;
    logic [WIDTH-1:0] res_next;

    full_adder u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {cell_sum, res_sr[WIDTH-1:1]};

    // Both flags decode straight from the state flop, so they carry no
    // combinational path from any input.
    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= cell_cout;
                    cnt    <= cnt + 1'b1;
                    // Final bit: publish the result on the same edge it completes.
                    if (cnt == LAST_BIT) begin
                        sum_out  <= res_next;
                        cout_out <= cell_cout;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start13 = 1'b0, cin13 = 1'b0;
    logic [12:0] a13 = '0, b13 = '0;
    logic        busy13, done13, cout13;
    logic [12:0] sum13;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
    );

    bit_serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a_in(a13), .b_in(b13), .cin(cin13),
        .busy(busy13), .done(done13), .sum_out(sum13), .cout_out(cout13)
    );

    // Drives one add on the selected instance (called #1 after a posedge) and
    // reports result, edges from accept to done, and whether done dropped after one cycle.
    task automatic add_op(input int w, input logic [12:0] a, input logic [12:0] b, input logic c,
                          output logic [12:0] s, output logic co, output int lat, output logic one);
        logic seen;
        if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = 1'b1; end
        else        begin a13 = a; b13 = b; cin13 = c; start13 = 1'b1; end
        @(posedge clk); #1;
        start8 = 1'b0; start13 = 1'b0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            seen = (w == 8) ? done8 : done13;
        end
        if (!seen) lat = -1;
        s  = (w == 8) ? {5'd0, sum8} : sum13;
        co = (w == 8) ? cout8 : cout13;
        @(posedge clk); #1;
        one = (w == 8) ? !done8 : !done13;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done8); end
        n_cmp++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum8); end
        n_cmp++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout8); end
        n_cmp++; if ({busy13, done13, sum13, cout13} !== '0) begin n_fail++; $display("FAIL reset_w13 got=%b%b_%h_%b exp=zeros", busy13, done13, sum13, cout13); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [12:0] s; logic co, one; int lat;
        add_op(8, 13'h5A, 13'h3C, 1'b0, s, co, lat, one);
        n_cmp++; if (s !== 13'h96) begin n_fail++; $display("FAIL basic_sum got=%h exp=96", s); end
        n_cmp++; if (co !== 1'b0) begin n_fail++; $display("FAIL basic_cout got=%b exp=0", co); end
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        n_cmp++; if (one !== 1'b1) begin n_fail++; $display("FAIL basic_done_width got=long exp=one_cycle"); end
    endtask

    task automatic test_carry;
        logic [12:0] s; logic co, one; int lat;
        add_op(8, 13'hFF, 13'h01, 1'b0, s, co, lat, one);
        n_cmp++; if ({co, s[7:0]} !== 9'h100) begin n_fail++; $display("FAIL carry_ff_01 got=%b_%h exp=1_00", co, s[7:0]); end
        add_op(8, 13'hFF, 13'h00, 1'b1, s, co, lat, one);
        n_cmp++; if ({co, s[7:0]} !== 9'h100) begin n_fail++; $display("FAIL carry_ff_cin got=%b_%h exp=1_00", co, s[7:0]); end
        add_op(8, 13'hFF, 13'hFF, 1'b1, s, co, lat, one);
        n_cmp++; if ({co, s[7:0]} !== 9'h1FF) begin n_fail++; $display("FAIL carry_max got=%b_%h exp=1_ff", co, s[7:0]); end
    endtask

    task automatic test_start_busy;
        int lat; logic seen;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        // Keep start asserted and scramble the operands for the whole shift.
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            if (i == 3) begin
                n_cmp++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL hold_busy got=%b exp=1", busy8); end
            end
            @(posedge clk); #1;
            lat++;
            seen = done8;
        end
        start8 = 1'b0;
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL hold_latency got=%0d exp=8", lat); end
        n_cmp++; if ({cout8, sum8} !== 9'h047) begin n_fail++; $display("FAIL hold_result got=%b_%h exp=0_47", cout8, sum8); end
        @(posedge clk); #1;
        n_cmp++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL hold_idle got=busy%b_done%b exp=busy0_done0", busy8, done8); end
    endtask

    task automatic test_back_to_back;
        int lat; logic seen;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin @(posedge clk); #1; seen = done8; end
        n_cmp++; if (sum8 !== 8'h30) begin n_fail++; $display("FAIL b2b_first got=%h exp=30", sum8); end
        // Request lands in the DONE cycle.
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_cmp++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b exp=1", busy8); end
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (i == 4) begin
                n_cmp++; if (sum8 !== 8'h30) begin n_fail++; $display("FAIL b2b_held got=%h exp=30", sum8); end
            end
            @(posedge clk); #1;
            lat++;
            seen = done8;
        end
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
        n_cmp++; if ({cout8, sum8} !== 9'h002) begin n_fail++; $display("FAIL b2b_second got=%b_%h exp=0_02", cout8, sum8); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [12:0] s; logic co, one; int lat; int pulses;
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy8, done8, cout8, sum8} !== 11'd0) begin n_fail++; $display("FAIL midrst_zero got=%b%b_%b_%h exp=00_0_00", busy8, done8, cout8, sum8); end
        @(posedge clk); #1 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (done8 || busy8) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
        add_op(8, 13'h80, 13'h81, 1'b1, s, co, lat, one);
        n_cmp++; if ({co, s[7:0]} !== 9'h102) begin n_fail++; $display("FAIL midrst_fresh got=%b_%h exp=1_02", co, s[7:0]); end
    endtask

    task automatic test_width13;
        logic [12:0] s; logic co, one; int lat;
        add_op(13, 13'h1FFF, 13'h0001, 1'b0, s, co, lat, one);
        n_cmp++; if ({co, s} !== 14'h2000) begin n_fail++; $display("FAIL w13_wrap got=%b_%h exp=1_0000", co, s); end
        n_cmp++; if (lat !== 13) begin n_fail++; $display("FAIL w13_latency got=%0d exp=13", lat); end
        add_op(13, 13'h0ABC, 13'h1234, 1'b1, s, co, lat, one);
        n_cmp++; if ({co, s} !== 14'h1CF1) begin n_fail++; $display("FAIL w13_mix got=%b_%h exp=0_1cf1", co, s); end
    endtask

    task automatic test_random(input int w);
        logic [12:0] a, b, s, mask; logic c, co, one; int lat; logic [13:0] full;
        mask = (w == 8) ? 13'h00FF : 13'h1FFF;
        for (int n = 0; n < 1000; n++) begin
            a = 13'($urandom) & mask;
            b = 13'($urandom) & mask;
            c = 1'($urandom);
            full = {1'b0, a} + {1'b0, b} + {13'd0, c};
            add_op(w, a, b, c, s, co, lat, one);
            n_cmp++; if (s !== (full[12:0] & mask) || co !== full[w]) begin n_fail++; $display("FAIL rand_w%0d a=%h b=%h c=%b got=%b_%h exp=%b_%h", w, a, b, c, co, s, full[w], full[12:0] & mask); end
            n_cmp++; if (lat !== w) begin n_fail++; $display("FAIL rand_lat_w%0d got=%0d exp=%0d", w, lat, w); end
            n_cmp++; if (one !== 1'b1) begin n_fail++; $display("FAIL rand_done_w%0d got=long exp=one_cycle", w); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_width13();
        test_random(8);
        test_random(13);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
